// File: rtl/acc_diff_decoder.sv
// Differencing decoder: recovers an accumulator's input samples from its running
// sums. It uses valid/ready handshakes and a one-entry registered output stage.
module acc_diff_decoder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             sync,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_delta,
  output logic             first_flag,
  output logic [CNT_W-1:0] sample_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] delta_q, delta_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             first_q, first_d;
  logic             zero_base_q, zero_base_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc;
  logic             use_zero;
  logic [WIDTH-1:0] base;

  assign in_ready   = (state_q == EMPTY) | out_ready;
  assign acc        = in_valid & in_ready;
  assign use_zero   = zero_base_q | sync;
  assign base       = use_zero ? '0 : prev_q;
  assign out_valid  = (state_q == FULL);
  assign out_delta  = delta_q;
  assign first_flag = first_q;
  assign sample_cnt = cnt_q;

  always_comb begin
    state_d     = state_q;
    delta_d     = delta_q;
    prev_d      = prev_q;
    first_d     = first_q;
    zero_base_d = zero_base_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      EMPTY:   if (acc) state_d = FULL;
      FULL:    if (out_ready && !acc) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (acc) begin
      delta_d     = in_sum - base;
      first_d     = use_zero;
      prev_d      = in_sum;
      zero_base_d = 1'b0;
      if (sync)
        cnt_d = CNT_W'(1);
      else if (cnt_q != '1)
        cnt_d = cnt_q + CNT_W'(1);
    end else if (sync) begin
      // Restart only arms the zero base; the held output is left untouched.
      zero_base_d = 1'b1;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= EMPTY;
      delta_q     <= '0;
      prev_q      <= '0;
      first_q     <= 1'b0;
      zero_base_q <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      delta_q     <= delta_d;
      prev_q      <= prev_d;
      first_q     <= first_d;
      zero_base_q <= zero_base_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
